// File: rtl/s0_fetch.sv
// s0_fetch: instruction-fetch stage; computes the fetch PC, drives the BIOS/IMEM read
// addresses and presents the fetched instruction to decode one cycle later.
// Ports:
//   clk, rst (async, active-low)
//   stall, redirect, redirect_pc        control from s1 (load-use) and s2 (branch/jump)
//   bios_addr, imem_addr                word addresses, driven every cycle
//   bios_dout, imem_dout                synchronous read data, 1 cycle after address
//   pc_s1, instruction_s1, valid_s1     contents of s1
//   fetch_fault                         sticky misaligned-redirect / unmapped-fetch flag
module s0_fetch #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [11:0] bios_addr,
    output logic [13:0] imem_addr,
    input  logic [31:0] bios_dout,
    input  logic [31:0] imem_dout,
    output logic [31:0] pc_s1,
    output logic [31:0] instruction_s1,
    output logic        valid_s1,
    output logic        fetch_fault
);
    typedef enum logic {BOOT, RUN} state_t;
    typedef enum logic [1:0] {NONE, BIOS, IMEM} src_t;
    state_t      state, state_nxt;
    src_t        src_q, src_d;
    logic [31:0] fetch_pc;
    logic        fault_d;
    // BOOT re-presents RESET_PC so the memories latch it; stall re-reads pc_s1 so the
    // synchronous read data (and thus instruction_s1) stays stable.
    always_comb begin
        state_nxt      = state;
        fetch_pc       = pc_s1;
        if (state == BOOT) state_nxt = RUN;
        else fetch_pc = redirect ? redirect_pc : stall ? pc_s1 : pc_s1 + 32'd4;
        src_d          = fetch_pc[31:28] == 4'h4 ? BIOS : fetch_pc[31:28] == 4'h1 ? IMEM : NONE;
        fault_d        = fetch_fault | (state == RUN &&
                         ((redirect && redirect_pc[1:0] != 2'b00) || src_d == NONE));
        valid_s1       = state == RUN && src_q != NONE;
        instruction_s1 = !valid_s1 ? NOP : src_q == BIOS ? bios_dout : imem_dout;
    end
    assign bios_addr = fetch_pc[13:2];
    assign imem_addr = fetch_pc[15:2];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= BOOT;
            pc_s1       <= RESET_PC;
            src_q       <= NONE;
            fetch_fault <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc_s1       <= fetch_pc;
            src_q       <= src_d;
            fetch_fault <= fault_d;
        end
    end
endmodule

// File: tb/tb_s0_fetch.sv
// tb_s0_fetch: self-checking bench for s0_fetch; directed scenarios plus a random
// stall/redirect phase compared against a PC-level reference model.
module tb_s0_fetch;
    localparam logic [31:0] RPC = 32'h4000_0000;
    localparam logic [31:0] NOPI = 32'h0000_0013;
    logic        clk = 1'b0, rst = 1'b0, stall = 1'b0, redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [11:0] bios_addr;
    logic [13:0] imem_addr;
    logic [31:0] bios_dout = '0, imem_dout = '0;
    logic [31:0] pc_s1, instruction_s1;
    logic        valid_s1, fetch_fault;
    logic [31:0] bios_mem [4096];
    logic [31:0] imem_mem [16384];
    int checks = 0, failures = 0;
    logic [31:0] m_pc;
    logic        m_boot, m_fault;

    s0_fetch dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .bios_addr(bios_addr), .imem_addr(imem_addr), .bios_dout(bios_dout), .imem_dout(imem_dout),
        .pc_s1(pc_s1), .instruction_s1(instruction_s1), .valid_s1(valid_s1), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;
    always @(posedge clk) begin
        bios_dout <= bios_mem[bios_addr];
        imem_dout <= imem_mem[imem_addr];
    end

    function automatic int region(input logic [31:0] a);
        return a[31:28] == 4'h4 ? 1 : a[31:28] == 4'h1 ? 2 : 0;
    endfunction

    function automatic logic [31:0] exp_instr();
        if (m_boot) return NOPI;
        case (region(m_pc))
            1: return bios_mem[m_pc[13:2]];
            2: return imem_mem[m_pc[15:2]];
            default: return NOPI;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("pc_s1", pc_s1, m_pc);
        chk("instruction_s1", instruction_s1, exp_instr());
        chk("valid_s1", {31'd0, valid_s1}, {31'd0, !m_boot && region(m_pc) != 0});
        chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
    endtask

    task automatic model_reset();
        m_pc = RPC; m_boot = 1'b1; m_fault = 1'b0;
    endtask

    task automatic step(input logic s, input logic r, input logic [31:0] rp);
        logic [31:0] nxt;
        stall = s; redirect = r; redirect_pc = rp;
        @(posedge clk);
        if (m_boot) begin
            nxt = m_pc;
            m_boot = 1'b0;
        end else begin
            nxt = r ? rp : s ? m_pc : m_pc + 32'd4;
            if ((r && rp[1:0] != 2'b00) || region(nxt) == 0) m_fault = 1'b1;
        end
        m_pc = nxt;
        #1 check_all();
    endtask

    task automatic release_reset();
        @(posedge clk); #1 rst = 1'b1;
        model_reset();
        check_all();
        chk("boot_valid", {31'd0, valid_s1}, 32'd0);
        chk("boot_instr", instruction_s1, NOPI);
        step(0, 0, 0);
        chk("first_pc", pc_s1, 32'h4000_0000);
        chk("first_instr", instruction_s1, bios_mem[0]);
        step(0, 0, 0);
        chk("second_pc", pc_s1, 32'h4000_0004);
    endtask

    initial begin
        logic [31:0] held_instr, tgt;
        for (int i = 0; i < 4096; i++) bios_mem[i] = $urandom;
        for (int i = 0; i < 16384; i++) imem_mem[i] = $urandom;
        model_reset();
        repeat (2) @(posedge clk);
        release_reset();
        while (m_pc != 32'h4000_0010) step(0, 0, 0);
        held_instr = instruction_s1;
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0);
            chk("stall_pc", pc_s1, 32'h4000_0010);
            chk("stall_instr", instruction_s1, held_instr);
        end
        step(0, 0, 0);
        chk("after_stall_pc", pc_s1, 32'h4000_0014);
        step(0, 1, 32'h1000_0000);
        chk("redir_pc", pc_s1, 32'h1000_0000);
        chk("redir_instr", instruction_s1, imem_mem[0]);
        step(1, 1, 32'h1000_0020);
        chk("redir_stall_pc", pc_s1, 32'h1000_0020);
        for (int i = 0; i < 300; i++) begin
            tgt = $urandom_range(0, 1) ? (32'h4000_0000 | ({$urandom} & 32'h0000_3FFC))
                                       : (32'h1000_0000 | ({$urandom} & 32'h0000_FFFC));
            step($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, tgt);
        end
        chk("no_fault_yet", {31'd0, fetch_fault}, 32'd0);
        step(0, 1, 32'h2000_0000);
        chk("none_valid", {31'd0, valid_s1}, 32'd0);
        chk("none_instr", instruction_s1, NOPI);
        chk("none_fault", {31'd0, fetch_fault}, 32'd1);
        step(0, 1, 32'h1000_0100);
        step(0, 0, 0);
        chk("fault_sticky", {31'd0, fetch_fault}, 32'd1);
        rst = 1'b0; #2 rst = 1'b1; model_reset(); #1;
        step(0, 0, 0);
        step(0, 0, 0);
        chk("clean_after_reset", {31'd0, fetch_fault}, 32'd0);
        step(0, 1, 32'h1000_0002);
        chk("misaligned_fault", {31'd0, fetch_fault}, 32'd1);
        chk("misaligned_instr", instruction_s1, imem_mem[0]);
        step(0, 1, 32'h1000_0040);
        chk("pre_reset_pc", pc_s1, 32'h1000_0040);
        #3 rst = 1'b0;
        #1;
        chk("async_pc", pc_s1, RPC);
        chk("async_valid", {31'd0, valid_s1}, 32'd0);
        chk("async_instr", instruction_s1, NOPI);
        chk("async_fault", {31'd0, fetch_fault}, 32'd0);
        release_reset();
        for (int i = 0; i < 5; i++) step(0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
